alu_mul_sequencer: RTL and testbench

Multi-cycle sequencer that computes a 32-bit product (low word, MUL semantics) by driving the shared 32-bit ALU through shift-and-add steps. It owns the ALU operand and control inputs while busy. It sits beside the ALU in the execute path. The top level instantiates the ALU and connects its `a`, `b`, `ALUControl`, `rslt` and `zero` to this block's `alu_*` ports.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu.sv | 35 +++
 rtl/alu_mul_sequencer.sv | 103 ++++++++++
 tb/tb_alu_mul_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes and the multiply sequencer state type.
// Imported by the ALU and by every block that drives it.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLL   = 4'd6;
  localparam logic [3:0] ALU_SRL   = 4'd7;
  localparam logic [3:0] ALU_SRA   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_JALR  = 4'd10;
  localparam logic [3:0] ALU_LUI   = 4'd11;
  localparam logic [3:0] ALU_AUIPC = 4'd12;

  typedef enum logic [2:0] {
    MUL_IDLE,
    MUL_ADD,
    MUL_SHL,
    MUL_SHR,
    MUL_DONE
  } mul_state_t;

endpackage

// File: rtl/alu.sv
// Shared 32-bit execute ALU; purely combinational, result and zero flag valid same cycle.
// No flow control: result follows operands and control directly.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  ALUControl,
  output logic [31:0] rslt,
  output logic        zero
);

  always_comb begin
    rslt = '0;
    case (ALUControl)
      ALU_ADD:   rslt = a + b;
      ALU_SUB:   rslt = a - b;
      ALU_AND:   rslt = a & b;
      ALU_OR:    rslt = a | b;
      ALU_XOR:   rslt = a ^ b;
      ALU_SLT:   rslt = {31'b0, $signed(a) < $signed(b)};
      ALU_SLL:   rslt = a << b[4:0];
      ALU_SRL:   rslt = a >> b[4:0];
      ALU_SRA:   rslt = 32'($signed(a) >>> b[4:0]);
      ALU_SLTU:  rslt = {31'b0, a < b};
      ALU_JALR:  rslt = (a + b) & ~32'd1;
      ALU_LUI:   rslt = b;
      ALU_AUIPC: rslt = a + b;
      default:   rslt = '0;
    endcase
  end

  assign zero = (rslt == 32'd0);

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 32-bit multiply (low word) run through the shared ALU, one ALU op per cycle.
// Latency 1 + sum(2 + bit) over processed multiplier bits; start is ignored while busy, flush aborts.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_rslt,
  input  logic        alu_zero
);

  mul_state_t  state;
  logic [31:0] acc;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [5:0]  bitcnt;

  assign busy    = (state != MUL_IDLE);
  assign done    = (state == MUL_DONE);
  assign product = acc;

  // The ALU is borrowed only in the step states; otherwise it sees a harmless 0+0.
  always_comb begin
    alu_a    = 32'd0;
    alu_b    = 32'd0;
    alu_ctrl = ALU_ADD;
    case (state)
      MUL_ADD: begin
        alu_a    = acc;
        alu_b    = mcand;
        alu_ctrl = ALU_ADD;
      end
      MUL_SHL: begin
        alu_a    = mcand;
        alu_b    = 32'd1;
        alu_ctrl = ALU_SLL;
      end
      MUL_SHR: begin
        alu_a    = mplier;
        alu_b    = 32'd1;
        alu_ctrl = ALU_SRL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= MUL_IDLE;
      acc    <= 32'd0;
      mcand  <= 32'd0;
      mplier <= 32'd0;
      bitcnt <= 6'd0;
    end else if (flush && state != MUL_IDLE) begin
      state <= MUL_IDLE;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            acc    <= 32'd0;
            mcand  <= op_a;
            mplier <= op_b;
            bitcnt <= 6'd0;
            if (EARLY_EXIT && op_b == 32'd0) state <= MUL_DONE;
            else if (op_b[0])                state <= MUL_ADD;
            else                             state <= MUL_SHL;
          end
        end
        MUL_ADD: begin
          acc   <= alu_rslt;
          state <= MUL_SHL;
        end
        MUL_SHL: begin
          mcand <= alu_rslt;
          state <= MUL_SHR;
        end
        MUL_SHR: begin
          mplier <= alu_rslt;
          bitcnt <= bitcnt + 6'd1;
          // alu_zero here reflects the freshly shifted multiplier: no set bits remain.
          if ((EARLY_EXIT && alu_zero) || bitcnt == 6'd31) state <= MUL_DONE;
          else if (alu_rslt[0])                            state <= MUL_ADD;
          else                                             state <= MUL_SHL;
        end
        MUL_DONE: state <= MUL_IDLE;
        default:  state <= MUL_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed and random multiplies on two sequencer+ALU pairs (early exit on and off),
// compared against a plain-arithmetic model of product, latency and ALU op order.
module tb_alu_mul_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0, flush1 = 1'b0;
  logic        start0 = 1'b0, flush0 = 1'b0;
  logic [31:0] op_a = 32'd0, op_b = 32'd0;

  logic        busy1, done1, zero1;
  logic [31:0] product1, alu_a1, alu_b1, rslt1;
  logic [3:0]  alu_ctrl1;
  logic        busy0, done0, zero0;
  logic [31:0] product0, alu_a0, alu_b0, rslt0;
  logic [3:0]  alu_ctrl0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_mul_sequencer #(.EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .flush(flush1),
    .op_a(op_a), .op_b(op_b), .busy(busy1), .done(done1), .product(product1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_ctrl(alu_ctrl1),
    .alu_rslt(rslt1), .alu_zero(zero1)
  );
  alu u_alu1 (.a(alu_a1), .b(alu_b1), .ALUControl(alu_ctrl1), .rslt(rslt1), .zero(zero1));

  alu_mul_sequencer #(.EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .flush(flush0),
    .op_a(op_a), .op_b(op_b), .busy(busy0), .done(done0), .product(product0),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_ctrl(alu_ctrl0),
    .alu_rslt(rslt0), .alu_zero(zero0)
  );
  alu u_alu0 (.a(alu_a0), .b(alu_b0), .ALUControl(alu_ctrl0), .rslt(rslt0), .zero(zero0));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic busy_of(input bit sel);
    return sel ? busy1 : busy0;
  endfunction
  function automatic logic done_of(input bit sel);
    return sel ? done1 : done0;
  endfunction
  function automatic logic [31:0] prod_of(input bit sel);
    return sel ? product1 : product0;
  endfunction
  function automatic logic [3:0] ctrl_of(input bit sel);
    return sel ? alu_ctrl1 : alu_ctrl0;
  endfunction

  // Every processed multiplier bit costs a shift pair, plus an add when the bit is set.
  function automatic int exp_lat(input logic [31:0] b, input bit ee);
    int n = 1;
    for (int i = 0; i < 32; i++)
      if (!ee || (b >> i) != 32'd0) n += 2 + int'(b[i]);
    return n;
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) start1 = v; else start0 = v;
  endtask
  task automatic set_flush(input bit sel, input logic v);
    if (sel) flush1 = v; else flush0 = v;
  endtask

  // flush_at: >0 flush in that cycle, -1 flush together with start, 0 none.
  // ign_at: cycle of an extra start pulse that must be ignored; ign_done pulses start during done.
  task automatic run(input bit sel, input logic [31:0] a, input logic [31:0] b,
                     input int flush_at, input int ign_at, input bit ign_done);
    int cyc, lat, mism, qi;
    logic [3:0]  expq[$];
    logic [31:0] exp_p;
    exp_p = a * b;
    for (int i = 0; i < 32; i++)
      if (!sel || (b >> i) != 32'd0) begin
        if (b[i]) expq.push_back(ALU_ADD);
        expq.push_back(ALU_SLL);
        expq.push_back(ALU_SRL);
      end
    @(posedge clk); #1;
    op_a = a;
    op_b = b;
    set_start(sel, 1'b1);
    if (flush_at < 0) set_flush(sel, 1'b1);
    cyc = 0; lat = -1; mism = 0; qi = 0;
    while (lat < 0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start1 = 1'b0; start0 = 1'b0; flush1 = 1'b0; flush0 = 1'b0;
      if (done_of(sel)) lat = cyc;
      else if (flush_at > 0 && cyc == flush_at + 1) break;
      else begin
        if (qi >= expq.size() || expq[qi] !== ctrl_of(sel)) mism++;
        qi++;
      end
      if (cyc == flush_at) set_flush(sel, 1'b1);
      if (cyc == ign_at && lat < 0) begin
        set_start(sel, 1'b1);
        op_a = 32'hdead_beef;
        op_b = 32'h0000_0003;
      end
    end
    if (flush_at > 0) begin
      check("flush_no_done", 32'(lat), 32'hffff_ffff);
      check("flush_idle_busy", 32'(busy_of(sel)), 32'd0);
      check("flush_prefix_ops", 32'(mism), 32'd0);
    end else begin
      check("latency", 32'(lat), 32'(exp_lat(b, sel)));
      check("product", prod_of(sel), exp_p);
      check("op_sequence", 32'(mism), 32'd0);
      check("op_count", 32'(qi), 32'(expq.size()));
      check("busy_in_done", 32'(busy_of(sel)), 32'd1);
      if (ign_done) begin
        set_start(sel, 1'b1);
        op_a = 32'h1111_1111;
        op_b = 32'h0000_0007;
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        check("start_in_done_ignored", 32'(busy_of(sel)), 32'd0);
        @(posedge clk); #1;
        check("start_not_queued", 32'(busy_of(sel)), 32'd0);
        check("product_held", prod_of(sel), exp_p);
      end
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          rsel;

    // Reset state
    #12;
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_product", product1, 32'd0);
    check("rst_alu_a", alu_a1, 32'd0);
    check("rst_alu_b", alu_b1, 32'd0);
    check("rst_alu_ctrl", 32'(alu_ctrl1), 32'(ALU_ADD));
    check("rst_busy_ee0", 32'(busy0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run(1'b1, 32'd3, 32'd5, 0, 0, 1'b0);
    run(1'b1, 32'h1234_5678, 32'd0, 0, 0, 1'b0);
    run(1'b0, 32'h1234_5678, 32'd0, 0, 0, 1'b0);
    run(1'b1, 32'hffff_ffff, 32'hffff_ffff, 0, 5, 1'b1);
    run(1'b1, 32'hffff_fffe, 32'd7, 0, 0, 1'b0);
    run(1'b0, 32'hffff_fffe, 32'd7, 0, 0, 1'b0);
    run(1'b1, 32'd6, 32'd7, 4, 0, 1'b0);
    run(1'b1, 32'd6, 32'd7, 0, 0, 1'b0);
    run(1'b1, 32'd9, 32'd11, -1, 0, 1'b0);

    // Randomized cases with a mix of multiplier widths
    for (int k = 0; k < 14; k++) begin
      rsel = 1'($urandom_range(0, 1));
      ra   = $urandom;
      case ($urandom_range(0, 2))
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(0, 255));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run(rsel, ra, rb, 0, 0, 1'b0);
    end

    // Asynchronous reset in the middle of an operation
    @(posedge clk); #1;
    op_a = 32'd5;
    op_b = 32'd3;
    start1 = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      start1 = 1'b0;
    end
    check("pre_reset_busy", 32'(busy1), 32'd1);
    check("pre_reset_acc", product1, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy1), 32'd0);
    check("midrst_done", 32'(done1), 32'd0);
    check("midrst_product", product1, 32'd0);
    check("midrst_alu_a", alu_a1, 32'd0);
    check("midrst_alu_b", alu_b1, 32'd0);
    check("midrst_alu_ctrl", 32'(alu_ctrl1), 32'(ALU_ADD));
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b1, 32'd5, 32'd3, 0, 0, 1'b0);
    run(1'b0, 32'hffff_fffe, 32'h8000_0001, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
